// File: rtl/iob_regfile_nr1w.sv
// Multi-read, single-write register file with byte strobes, optional
// registered reads with write forwarding, and a one-register-per-cycle
// sweep clear.
//
// state  | meaning
// IDLE   | normal operation, writes accepted
// CLEAR  | sweeping reg[cnt_q] to zero, writes and clr_i ignored
module iob_regfile_nr1w #(
   parameter int N        = 16,
   parameter int W        = 32,
   parameter int NR_PORTS = 2,
   parameter int ADDR_W   = $clog2(N),
   parameter int RD_LAT   = 1,
   parameter int BYPASS   = 1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         cke_i,
   input  logic                         wen_i,
   input  logic [ADDR_W-1:0]            waddr_i,
   input  logic [W/8-1:0]               wstrb_i,
   input  logic [W-1:0]                 wdata_i,
   input  logic [NR_PORTS*ADDR_W-1:0]   raddr_i,
   output logic [NR_PORTS*W-1:0]        rdata_o,
   input  logic                         clr_i,
   output logic                         busy_o
);

   localparam int NB = W / 8;

   typedef enum logic [0:0] {ST_IDLE, ST_CLEAR} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [W-1:0]        mem_q [N];
   logic [W-1:0]        mem_d [N];
   logic                wr_en;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return 32'(a) < 32'(N);
   endfunction

   function automatic logic [W-1:0] merge(input logic [W-1:0] old_v,
                                          input logic [W-1:0] new_v,
                                          input logic [NB-1:0] strb);
      logic [W-1:0] res;
      res = old_v;
      for (int b = 0; b < NB; b++) begin
         if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
      end
      return res;
   endfunction

   function automatic logic [W-1:0] rd_word(input logic [ADDR_W-1:0] a);
      return in_range(a) ? mem_q[a] : '0;
   endfunction

   // Next-state for the FSM, sweep counter and storage; clear beats write.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
      for (int i = 0; i < N; i++) mem_d[i] = mem_q[i];
      if (cke_i) begin
         case (state_q)
            ST_IDLE: begin
               if (clr_i) begin
                  state_d = ST_CLEAR;
                  cnt_d   = '0;
               end else if (wen_i && in_range(waddr_i) && (|wstrb_i)) begin
                  wr_en          = 1'b1;
                  mem_d[waddr_i] = merge(mem_q[waddr_i], wdata_i, wstrb_i);
               end
            end
            ST_CLEAR: begin
               mem_d[cnt_q] = '0;
               cnt_d        = cnt_q + 1'b1;
               if (cnt_q == ADDR_W'(N - 1)) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State registers; reset overrides clock enable.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         for (int i = 0; i < N; i++) mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         for (int i = 0; i < N; i++) mem_q[i] <= mem_d[i];
      end
   end

   assign busy_o = (state_q == ST_CLEAR);

   generate
      if (RD_LAT == 0) begin : g_rd_comb
         // Asynchronous read ports.
         always_comb begin
            rdata_o = '0;
            for (int k = 0; k < NR_PORTS; k++) begin
               rdata_o[k*W +: W] = rd_word(raddr_i[k*ADDR_W +: ADDR_W]);
            end
         end
      end else begin : g_rd_reg
         logic [NR_PORTS*W-1:0] rdata_q, rdata_d;

         // Registered read ports, optionally forwarding a same-cycle write.
         always_comb begin
            rdata_d = rdata_q;
            if (cke_i) begin
               for (int k = 0; k < NR_PORTS; k++) begin
                  rdata_d[k*W +: W] = rd_word(raddr_i[k*ADDR_W +: ADDR_W]);
                  if ((BYPASS != 0) && wr_en &&
                      (raddr_i[k*ADDR_W +: ADDR_W] == waddr_i)) begin
                     rdata_d[k*W +: W] = merge(rd_word(raddr_i[k*ADDR_W +: ADDR_W]),
                                               wdata_i, wstrb_i);
                  end
               end
            end
         end

         // Read output register.
         always_ff @(posedge clk_i) begin
            if (rst_i) rdata_q <= '0;
            else       rdata_q <= rdata_d;
         end

         assign rdata_o = rdata_q;
      end
   endgenerate

endmodule

// File: tb/tb_iob_regfile_nr1w.sv
// Directed bench: three instances sharing stimulus (registered+bypass,
// registered without bypass, combinational N=12 single port).
module tb_iob_regfile_nr1w;

   logic        clk = 1'b0;
   logic        rst, cke, wen, clr;
   logic [3:0]  waddr, wstrb, ra0, ra1;
   logic [31:0] wdata;
   logic [63:0] rd_a, rd_b;
   logic [31:0] rd_c;
   logic        busy_a, busy_b, busy_c;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   iob_regfile_nr1w dut_a (
      .clk_i(clk), .rst_i(rst), .cke_i(cke), .wen_i(wen), .waddr_i(waddr),
      .wstrb_i(wstrb), .wdata_i(wdata), .raddr_i({ra1, ra0}), .rdata_o(rd_a),
      .clr_i(clr), .busy_o(busy_a));

   iob_regfile_nr1w #(.BYPASS(0)) dut_b (
      .clk_i(clk), .rst_i(rst), .cke_i(cke), .wen_i(wen), .waddr_i(waddr),
      .wstrb_i(wstrb), .wdata_i(wdata), .raddr_i({ra1, ra0}), .rdata_o(rd_b),
      .clr_i(clr), .busy_o(busy_b));

   iob_regfile_nr1w #(.N(12), .NR_PORTS(1), .RD_LAT(0)) dut_c (
      .clk_i(clk), .rst_i(rst), .cke_i(cke), .wen_i(wen), .waddr_i(waddr),
      .wstrb_i(wstrb), .wdata_i(wdata), .raddr_i(ra0), .rdata_o(rd_c),
      .clr_i(clr), .busy_o(busy_c));

   typedef struct {
      logic        wen;
      logic [3:0]  wa;
      logic [3:0]  st;
      logic [31:0] wd;
      logic [3:0]  r0;
      logic [3:0]  r1;
      logic [31:0] ea0;
      logic [31:0] ea1;
      logic [31:0] eb0;
      logic [31:0] eb1;
      logic [31:0] ec;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int cnt_a, cnt_b, cnt_c;

      vecs[0] = '{1'b1, 4'd3,  4'hF, 32'hDEADBEEF, 4'd3,  4'd3,
                  32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h0, 32'hDEADBEEF};
      vecs[1] = '{1'b1, 4'd3,  4'h5, 32'h11223344, 4'd3,  4'd0,
                  32'hDE22BE44, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDE22BE44};
      vecs[2] = '{1'b0, 4'd0,  4'h0, 32'h0,        4'd3,  4'd3,
                  32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44};
      vecs[3] = '{1'b1, 4'd5,  4'hF, 32'hA5A5A5A5, 4'd5,  4'd5,
                  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 32'h0, 32'hA5A5A5A5};
      vecs[4] = '{1'b0, 4'd0,  4'h0, 32'h0,        4'd5,  4'd3,
                  32'hA5A5A5A5, 32'hDE22BE44, 32'hA5A5A5A5, 32'hDE22BE44, 32'hA5A5A5A5};
      vecs[5] = '{1'b1, 4'd7,  4'h0, 32'hFFFFFFFF, 4'd7,  4'd7,
                  32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      vecs[6] = '{1'b1, 4'd7,  4'h8, 32'hCAFEBABE, 4'd7,  4'd5,
                  32'hCA000000, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, 32'hCA000000};
      vecs[7] = '{1'b0, 4'd0,  4'h0, 32'h0,        4'd7,  4'd15,
                  32'hCA000000, 32'h0, 32'hCA000000, 32'h0, 32'hCA000000};
      vecs[8] = '{1'b1, 4'd15, 4'h3, 32'h1234ABCD, 4'd15, 4'd15,
                  32'h0000ABCD, 32'h0000ABCD, 32'h0, 32'h0, 32'h0};
      vecs[9] = '{1'b0, 4'd0,  4'h0, 32'h0,        4'd15, 4'd3,
                  32'h0000ABCD, 32'hDE22BE44, 32'h0000ABCD, 32'hDE22BE44, 32'h0};

      rst = 1'b1; cke = 1'b1; wen = 1'b0; clr = 1'b0;
      waddr = '0; wstrb = '0; wdata = '0; ra0 = '0; ra1 = '0;
      step();
      step();
      chk("rst_busy_a", busy_a, 1'b0);
      chk("rst_busy_c", busy_c, 1'b0);
      chk("rst_rd_a0", rd_a[31:0], 32'h0);
      chk("rst_rd_a1", rd_a[63:32], 32'h0);
      chk("rst_rd_c", rd_c, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         wen = vecs[i].wen; waddr = vecs[i].wa; wstrb = vecs[i].st;
         wdata = vecs[i].wd; ra0 = vecs[i].r0; ra1 = vecs[i].r1;
         step();
         chk($sformatf("vec%0d_a0", i), rd_a[31:0],  vecs[i].ea0);
         chk($sformatf("vec%0d_a1", i), rd_a[63:32], vecs[i].ea1);
         chk($sformatf("vec%0d_b0", i), rd_b[31:0],  vecs[i].eb0);
         chk($sformatf("vec%0d_b1", i), rd_b[63:32], vecs[i].eb1);
         chk($sformatf("vec%0d_c",  i), rd_c,        vecs[i].ec);
      end

      // Clock-enable freeze with write and clear requested.
      cke = 1'b0; wen = 1'b1; waddr = 4'd3; wstrb = 4'hF; wdata = 32'hFFFFFFFF;
      clr = 1'b1; ra0 = 4'd5; ra1 = 4'd3;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("frz%0d_a0", i), rd_a[31:0],  32'h0000ABCD);
         chk($sformatf("frz%0d_a1", i), rd_a[63:32], 32'hDE22BE44);
         chk($sformatf("frz%0d_b0", i), rd_b[31:0],  32'h0000ABCD);
         chk($sformatf("frz%0d_busy", i), busy_a, 1'b0);
         chk($sformatf("frz%0d_busyc", i), busy_c, 1'b0);
      end
      ra0 = 4'd14;
      #1;
      chk("oor_c_addr14", rd_c, 32'h0);
      cke = 1'b1; wen = 1'b0; clr = 1'b0; ra0 = 4'd5;
      step();
      chk("unfrz_a0", rd_a[31:0],  32'hA5A5A5A5);
      chk("unfrz_a1", rd_a[63:32], 32'hDE22BE44);
      chk("unfrz_busy", busy_a, 1'b0);

      // Fill every register.
      for (int i = 0; i < 16; i++) begin
         wen = 1'b1; waddr = 4'(i); wstrb = 4'hF; wdata = 32'h10000000 | i;
         step();
      end
      wen = 1'b0; ra0 = 4'd9; ra1 = 4'd15;
      step();
      chk("fill_a0", rd_a[31:0],  32'h10000009);
      chk("fill_a1", rd_a[63:32], 32'h1000000F);
      chk("fill_c",  rd_c,        32'h10000009);

      // Clear and write together: clear wins; writes during busy dropped.
      clr = 1'b1; wen = 1'b1; waddr = 4'd2; wdata = 32'h12345678; wstrb = 4'hF;
      ra0 = 4'd15;
      step();
      clr = 1'b0; waddr = 4'd4; wdata = 32'hFFFFFFFF;
      cnt_a = 0; cnt_b = 0; cnt_c = 0;
      while (busy_a && cnt_a < 40) begin
         cnt_a++;
         if (busy_b) cnt_b++;
         if (busy_c) cnt_c++;
         if (cnt_a == 3) chk("partial_clr_a0", rd_a[31:0], 32'h1000000F);
         if (cnt_a == 4) wen = 1'b0;
         step();
      end
      wen = 1'b0;
      chk("busy_len_a", cnt_a, 16);
      chk("busy_len_b", cnt_b, 16);
      chk("busy_len_c", cnt_c, 12);
      for (int i = 0; i < 16; i++) begin
         ra0 = 4'(i); ra1 = 4'(15 - i);
         step();
         chk($sformatf("clr%0d_a0", i), rd_a[31:0],  32'h0);
         chk($sformatf("clr%0d_a1", i), rd_a[63:32], 32'h0);
         chk($sformatf("clr%0d_b0", i), rd_b[31:0],  32'h0);
         chk($sformatf("clr%0d_c",  i), rd_c,        32'h0);
      end

      // Reset in the middle of a sweep, with write and clear also requested.
      wen = 1'b1; wstrb = 4'hF; waddr = 4'd10; wdata = 32'h000000AA;
      step();
      waddr = 4'd1; wdata = 32'h00000055;
      step();
      wen = 1'b0; ra0 = 4'd10; ra1 = 4'd1;
      step();
      chk("pre_rst_a0", rd_a[31:0],  32'h000000AA);
      chk("pre_rst_a1", rd_a[63:32], 32'h00000055);
      clr = 1'b1;
      step();
      clr = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("sweep_c5_busy", busy_a, 1'b1);
      rst = 1'b1; wen = 1'b1; waddr = 4'd10; wdata = 32'h00000077; clr = 1'b1;
      step();
      chk("rst_mid_busy_a", busy_a, 1'b0);
      chk("rst_mid_busy_c", busy_c, 1'b0);
      chk("rst_mid_a0", rd_a[31:0],  32'h0);
      chk("rst_mid_a1", rd_a[63:32], 32'h0);
      chk("rst_mid_c",  rd_c,        32'h0);
      rst = 1'b0; wen = 1'b0; clr = 1'b0;
      step();
      chk("post_rst_busy", busy_a, 1'b0);
      chk("post_rst_a0", rd_a[31:0], 32'h0);
      for (int i = 0; i < 16; i++) begin
         ra0 = 4'(i); ra1 = 4'(15 - i);
         step();
         chk($sformatf("rst%0d_a0", i), rd_a[31:0],  32'h0);
         chk($sformatf("rst%0d_a1", i), rd_a[63:32], 32'h0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
